// File: rtl/uart_rx.sv
// 8N1-style serial receiver: two-flop line synchroniser, mid-bit sampling FSM,
// and a one-entry valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 115200,
   parameter int CLK_FREQ   = 100_000_000
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  rx_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  frame_err_o,
   output logic                  overrun_o
);

   localparam int CPB  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB) + 1;
   localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   generate
      if (CPB < 4) begin : g_cpb_check
         $error("uart_rx: clocks per bit (%0d) must be at least 4", CPB);
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } state_e;

   logic                  rx_meta_q;
   logic                  rx_s_q;
   state_e                state_q,  state_d;
   logic [CW-1:0]         cnt_q,    cnt_d;
   logic [BW-1:0]         bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0] shift_q,  shift_d;
   logic                  done_q,   done_d;
   logic                  ferr_q,   ferr_d;
   logic                  valid_q,  valid_d;
   logic [DATA_WIDTH-1:0] data_q,   data_d;
   logic                  ovr_q,    ovr_d;
   logic [DATA_WIDTH:0]   ext_s;

   // Line synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   // FSM, counters, shift register and event pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   // Incoming sample enters at the MSB so the first data bit lands in bit 0.
   assign ext_s = {rx_s_q, shift_q};

   // Next-state logic for the receive FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = '0;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               if (!rx_s_q) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = ext_s[DATA_WIDTH:1];
               if (bit_idx_q == BIT_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT_IDLE: begin
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // One-entry output register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   // A completed word is dropped only when the held word is not being taken.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovr_d   = 1'b0;
      if (done_q) begin
         if (valid_q && !ready_i) begin
            ovr_d = 1'b1;
         end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   assign valid_o     = valid_q;
   assign data_o      = data_q;
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are bit-banged onto rx_i, expected words are
// queued as they are sent and checked as the receiver hands them over.
module tb_uart_rx;

   localparam int CPB = 10;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       rx_i;
   logic       ready_i;
   logic       valid_o;
   logic [7:0] data_o;
   logic       frame_err_o;
   logic       overrun_o;

   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;
   int         n_vhigh = 0;
   int         n_ferr = 0;
   int         n_ovr = 0;
   int         n_acc = 0;
   int         start_cyc = 0;
   int         rise_cyc = 0;
   logic [7:0] sb [$];

   uart_rx #(
      .DATA_WIDTH (8),
      .BAUD_RATE  (100_000),
      .CLK_FREQ   (1_000_000)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rx_i        (rx_i),
      .ready_i     (ready_i),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic monitor();
      logic       prev_v;
      logic [7:0] exp_w;
      prev_v = 1'b0;
      forever begin
         @(negedge clk_i);
         if (valid_o && !prev_v) rise_cyc = cyc;
         prev_v = valid_o;
         if (valid_o)     n_vhigh++;
         if (frame_err_o) n_ferr++;
         if (overrun_o)   n_ovr++;
         if (valid_o && ready_i) begin
            n_acc++;
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL spurious_word observed=0x%0h expected=none", data_o);
            end else begin
               exp_w = sb.pop_front();
               chk("data", int'(data_o), int'(exp_w));
            end
         end
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_i = b;
      repeat (CPB) @(posedge clk_i);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 300;
      while (sb.size() != 0 && budget > 0) begin
         @(posedge clk_i);
         budget--;
      end
      idle(5);
      chk(name, sb.size(), 0);
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_valid"}, int'(valid_o), 0);
      chk({pfx, "_data"}, int'(data_o), 0);
      chk({pfx, "_ferr"}, int'(frame_err_o), 0);
      chk({pfx, "_ovr"}, int'(overrun_o), 0);
   endtask

   initial begin
      int v0, f0, o0, a0, lat;
      rst_ni  = 1'b0;
      rx_i    = 1'b1;
      ready_i = 1'b1;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk_i);
      #1;
      chk_outputs_zero("reset");
      rst_ni = 1'b1;
      idle(5);

      // Single frame with latency measurement.
      v0 = n_vhigh; f0 = n_ferr; o0 = n_ovr;
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      drain("a5_drain");
      lat = rise_cyc - start_cyc;
      chk("a5_latency_in_97_99", int'(lat >= 97 && lat <= 99), 1);
      chk("a5_valid_cycles", n_vhigh - v0, 1);
      chk("a5_ferr", n_ferr - f0, 0);
      chk("a5_ovr", n_ovr - o0, 0);

      // Back-to-back frames with no idle gap.
      a0 = n_acc;
      sb.push_back(8'h00);
      sb.push_back(8'hFF);
      sb.push_back(8'h3C);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      drain("b2b_drain");
      chk("b2b_count", n_acc - a0, 3);

      // Glitch shorter than half a bit must be rejected.
      v0 = n_vhigh;
      rx_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      idle(30);
      chk("glitch_no_valid", n_vhigh - v0, 0);
      sb.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      drain("glitch_5a_drain");

      // Framing error followed by a held-low line.
      v0 = n_vhigh; f0 = n_ferr;
      send_frame(8'h81, 1'b0);
      rx_i = 1'b0;
      repeat (40) @(posedge clk_i);
      #1;
      idle(20);
      chk("ferr_pulse_cycles", n_ferr - f0, 1);
      chk("ferr_no_valid", n_vhigh - v0, 0);
      sb.push_back(8'h42);
      send_frame(8'h42, 1'b1);
      drain("ferr_42_drain");

      // Overrun with the consumer stalled.
      ready_i = 1'b0;
      o0 = n_ovr; a0 = n_acc;
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(10);
      chk("ovr_pulse_cycles", n_ovr - o0, 1);
      chk("ovr_held_data", int'(data_o), 8'h11);
      chk("ovr_held_valid", int'(valid_o), 1);
      chk("ovr_no_accept", n_acc - a0, 0);
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("ovr_valid_drop", int'(valid_o), 0);
      chk("ovr_accepted", n_acc - a0, 1);
      chk("ovr_queue_empty", sb.size(), 0);

      // Reset in the middle of data bit 4 of 0x77.
      a0 = n_acc;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i));
      rx_i = 1'b1;
      repeat (5) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #2;
      chk_outputs_zero("midrst");
      repeat (3) @(posedge clk_i);
      #1;
      chk_outputs_zero("midrst_hold");
      rst_ni = 1'b1;
      idle(20);
      chk("midrst_no_word", n_acc - a0, 0);
      sb.push_back(8'h99);
      send_frame(8'h99, 1'b1);
      drain("midrst_99_drain");
      chk("midrst_one_word", n_acc - a0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1-style frames (1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit, no parity).
- Sits directly upstream of the UART register interface, which instantiates it with DATA_WIDTH=8 and ready_i tied high.
- Synchronises the line, samples each bit at mid-bit, presents each received word through a one-entry valid/ready output register.
- Flags framing errors and overruns.

Parameters:
- DATA_WIDTH, 8, data bits per frame (1..16)
- BAUD_RATE, 115200, line bit rate in bit/s
- CLK_FREQ, 100_000_000, clk_i frequency in Hz

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- rx_i  input  1  serial line, idle high, asynchronous to clk_i
- ready_i  input  1  consumer accepts data_o this cycle
- valid_o  output  1  data_o holds an unconsumed word
- data_o  output  DATA_WIDTH  received word
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- overrun_o  output  1  one-cycle pulse: word completed while output register still full

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low. All flops reset asynchronously.
- Reset values:
  - Synchroniser flops = 1.
  - State = IDLE; counters = 0; shift register = 0.
  - valid_o = 0, data_o = 0, frame_err_o = 0, overrun_o = 0.
- Timing constants:
  - CPB = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, integer, rounded to nearest.
  - HALF = CPB/2, truncated.
  - Elaboration assertion: CPB >= 4.
  - Baud counter width = $clog2(CPB)+1.
- Input synchroniser:
  - rx_i passes through 2 flops; rx_s is the second flop.
  - All FSM decisions use rx_s only.
- FSM states:
  - IDLE: on rx_s==0, load baud counter with 0, go to START.
  - START: count to HALF-1. Then sample rx_s.
    - Sample 0: go to DATA, counter = 0, bit index = 0.
    - Sample 1 (glitch / false start): return to IDLE, no output.
  - DATA: each time the counter reaches CPB-1, sample rx_s and reset the counter.
    - Shift right: sample enters the MSB, so the first bit received ends in bit 0.
    - After DATA_WIDTH samples, go to STOP.
  - STOP: at counter == CPB-1, sample rx_s.
    - Sample 1: word complete; go to IDLE.
    - Sample 0: frame_err_o pulses for 1 cycle, word discarded (valid_o unchanged). Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. Prevents a break condition being decoded as repeated 0x00 frames.
- Output register (one entry):
  - Completion cycle = the clk_i edge at which the stop bit is sampled high.
  - On the next edge, with valid_o==0 or ready_i==1: data_o <= word, valid_o <= 1.
  - If valid_o==1 and ready_i==0 at completion: overrun_o pulses 1 cycle, new word dropped, data_o and valid_o unchanged.
  - Handshake: valid_o && ready_i in a cycle without a new completion → valid_o <= 0 next edge.
  - Simultaneous accept and completion: data_o replaced, valid_o stays 1, no overrun.
  - data_o is stable while valid_o==1 && ready_i==0.
- Latency: valid_o rises 1 clk_i cycle after the stop-bit sample edge.
  - Start-edge sample to stop sample ≈ HALF + (DATA_WIDTH+1)*CPB cycles.
  - Add 2 cycles of synchroniser delay from rx_i.
- Back-to-back frames: a start edge seen in IDLE right after STOP is accepted; there is no dead time beyond the 1 cycle spent in IDLE.
- Reset mid-frame: everything returns to reset values immediately. A partially received frame is lost. If the line is low when reset is released, the FSM enters START and relies on false-start rejection or normal decoding.

Test Plan:
- All cases use CLK_FREQ=1_000_000, BAUD_RATE=100_000 (CPB=10, HALF=5), DATA_WIDTH=8, ready_i=1 unless stated.
- Single frame 0xA5, bits 10 cycles each → valid_o high exactly 1 cycle, data_o=0xA5, frame_err_o=0, overrun_o=0; valid_o rises 2+5+90+1 cycles after the start edge on rx_i (±1).
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap → three valid_o pulses, data_o 0x00, 0xFF, 0x3C in order.
- rx_i low for 3 cycles then high (glitch) → no valid_o, FSM back in IDLE; a following 0x5A frame is received correctly.
- Frame 0x81 with stop bit low, line held low for 40 more cycles, then high → frame_err_o one pulse, no valid_o, no spurious 0x00; a following 0x42 frame is received.
- ready_i=0; send 0x11 then 0x22 → data_o=0x11 held with valid_o=1, overrun_o pulses once at the 0x22 completion. Raise ready_i → valid_o drops the next cycle.
- Assert rst_ni low in the middle of data bit 4 of 0x77, release while the line is idle, then send 0x99 → all outputs 0 during reset, then exactly one word 0x99.
